an_decoder_barrett_pipe: RTL

AN_DECODER_BARRETT_PIPE -- requirements
Module: an_decoder_barrett_pipe

---
 rtl/an_decoder_barrett_pipe.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/an_decoder_barrett_pipe.sv
// an_decoder_barrett_pipe: 3-stage AN-code decoder, Barrett divide by A plus single-bit error correction
module an_decoder_barrett_pipe #(
    parameter int A = 29,
    parameter int MSG_W = 10,
    parameter int CW_W = 15,
    parameter int ERR_BITS = 14,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW_W-1:0]  in_cw,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MSG_W-1:0] out_msg,
    output logic             out_corr,
    output logic             out_uncorr,
    output logic [4:0]       out_pos,
    output logic             out_neg,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_corr,
    output logic [CNT_W-1:0] cnt_uncorr
);
    localparam int K = 2 * CW_W;
    localparam logic [K-1:0] MU = K'((64'd1 << K) / 64'(A));
    localparam logic [CW_W-1:0] AW = CW_W'(A);

    function automatic logic [CW_W-1:0] pres(input int i);
        return CW_W'((64'd1 << i) % 64'(A));
    endfunction

    function automatic logic [CW_W-1:0] nres(input int i);
        return AW - pres(i);
    endfunction

    function automatic logic [CW_W-1:0] fl(input int i);
        return CW_W'((64'd1 << i) / 64'(A));
    endfunction

    function automatic logic [CW_W-1:0] ce(input int i);
        return CW_W'(((64'd1 << i) + 64'(A) - 64'd1) / 64'(A));
    endfunction

    function automatic logic [CW_W-1:0] rv(input int a);
        return a < ERR_BITS ? pres(a) : nres(a - ERR_BITS);
    endfunction

    function automatic bit tbl_ok();
        for (int a = 0; a < 2 * ERR_BITS; a++) begin
            if (rv(a) == '0) return 1'b0;
            for (int b = a + 1; b < 2 * ERR_BITS; b++)
                if (rv(a) == rv(b)) return 1'b0;
        end
        return 1'b1;
    endfunction

    if (A < 3 || A > 255 || A % 2 == 0) begin : g_bad_a
        $error("A must be odd and in 3..255");
    end
    if (((64'd1 << MSG_W) - 64'd1) * 64'(A) >= (64'd1 << CW_W)) begin : g_bad_cw
        $error("CW_W too narrow for MSG_W and A");
    end
    if (!tbl_ok()) begin : g_bad_tbl
        $error("correction residues not nonzero and distinct");
    end

    logic                   adv, v1, v2, hit, nf, corr;
    logic [CW_W-1:0]        cw1, q2, r2, q_est, qf, rf;
    logic [CW_W+K-1:0]      p1;
    logic signed [CW_W:0]   cv;
    logic [4:0]             pf;
    logic [MSG_W-1:0]       mf;

    assign adv = !out_valid || out_ready;
    assign in_ready = adv;
    assign q_est = p1[CW_W+K-1:K];
    // q_est is at most one short, so a single conditional step finishes the division
    assign qf = r2 >= AW ? q2 + 1'b1 : q2;
    assign rf = r2 >= AW ? r2 - AW : r2;

    always_comb begin
        hit = 1'b0;
        cv = '0;
        pf = '0;
        nf = 1'b0;
        for (int i = 0; i < ERR_BITS; i++) begin
            if (rf == pres(i)) begin
                hit = 1'b1;
                cv = $signed({1'b0, qf}) - $signed({1'b0, fl(i)});
                pf = 5'(i);
                nf = 1'b0;
            end
            if (rf == nres(i)) begin
                hit = 1'b1;
                cv = $signed({1'b0, qf}) + $signed({1'b0, ce(i)});
                pf = 5'(i);
                nf = 1'b1;
            end
        end
        corr = hit && !cv[CW_W] && cv[CW_W-1:MSG_W] == '0;
        mf = corr ? cv[MSG_W-1:0] : qf[MSG_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            cw1 <= '0;
            p1 <= '0;
            q2 <= '0;
            r2 <= '0;
            out_valid <= 1'b0;
            out_msg <= '0;
            out_corr <= 1'b0;
            out_uncorr <= 1'b0;
            out_pos <= '0;
            out_neg <= 1'b0;
        end else if (adv) begin
            v1 <= in_valid;
            cw1 <= in_cw;
            p1 <= (CW_W+K)'(in_cw) * (CW_W+K)'(MU);
            v2 <= v1;
            q2 <= q_est;
            r2 <= cw1 - q_est * AW;
            out_valid <= v2;
            out_msg <= mf;
            out_corr <= corr;
            out_uncorr <= rf != '0 && !corr;
            out_pos <= corr ? pf : '0;
            out_neg <= corr && nf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt_corr <= '0;
            cnt_uncorr <= '0;
        end else if (out_valid && out_ready) begin
            if (out_corr && cnt_corr != '1) cnt_corr <= cnt_corr + 1'b1;
            if (out_uncorr && cnt_uncorr != '1) cnt_uncorr <= cnt_uncorr + 1'b1;
        end
    end
endmodule
